// File: rtl/sa_module_core_if.sv
// Operand, start and result bundle for sa_module_core.
// The master drives the 4x4 matrix A, the 3x3 kernel B and the start strobe; the slave returns the serialized results.
interface sa_module_core_if;
  logic       en_sa;
  logic [7:0] a_1_1, a_1_2, a_1_3, a_1_4;
  logic [7:0] a_2_1, a_2_2, a_2_3, a_2_4;
  logic [7:0] a_3_1, a_3_2, a_3_3, a_3_4;
  logic [7:0] a_4_1, a_4_2, a_4_3, a_4_4;
  logic [7:0] b_1_1, b_1_2, b_1_3;
  logic [7:0] b_2_1, b_2_2, b_2_3;
  logic [7:0] b_3_1, b_3_2, b_3_3;
  logic       sa_en_result;
  logic [7:0] sa_result;

  modport master (
    output en_sa,
    output a_1_1, a_1_2, a_1_3, a_1_4, a_2_1, a_2_2, a_2_3, a_2_4,
    output a_3_1, a_3_2, a_3_3, a_3_4, a_4_1, a_4_2, a_4_3, a_4_4,
    output b_1_1, b_1_2, b_1_3, b_2_1, b_2_2, b_2_3, b_3_1, b_3_2, b_3_3,
    input  sa_en_result, sa_result
  );

  modport slave (
    input  en_sa,
    input  a_1_1, a_1_2, a_1_3, a_1_4, a_2_1, a_2_2, a_2_3, a_2_4,
    input  a_3_1, a_3_2, a_3_3, a_3_4, a_4_1, a_4_2, a_4_3, a_4_4,
    input  b_1_1, b_1_2, b_1_3, b_2_1, b_2_2, b_2_3, b_3_1, b_3_2, b_3_3,
    output sa_en_result, sa_result
  );
endinterface

// File: rtl/sa_module_core.sv
// 2x2 valid correlation of a 4x4 matrix with a 3x3 kernel on a weight-stationary 3x3 systolic array.
// Four saturated results leave one per cycle, starting six edges after an accepted start.
module sa_module_core (
  input  logic            clk,
  input  logic            reset,
  sa_module_core_if.slave io_sa
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, COMPUTE = 2'd2, OUTPUT = 2'd3} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [7:0]  r_a   [0:3][0:3];
  logic [7:0]  r_b   [0:2][0:2];
  logic [19:0] r_ps  [0:2][0:2];
  logic [7:0]  r_res [0:3];
  logic        r_vld;
  logic [7:0]  r_out;

  logic [7:0]  w_a_in    [0:3][0:3];
  logic [7:0]  w_b_in    [0:2][0:2];
  logic [3:0]  w_k       [0:2];
  logic        w_row_vld [0:2];
  logic [7:0]  w_feed    [0:2][0:2];
  logic [15:0] w_prod    [0:2][0:2];
  logic [19:0] w_ps_in   [0:2][0:2];
  logic [19:0] w_sum;
  logic [1:0]  w_cap_idx, w_out_idx;
  logic        w_start, w_cap, w_out_vld;

  function automatic logic [7:0] sat8(input logic [19:0] v);
    logic [7:0] s;
    if (v > 20'd255) s = 8'd255;
    else             s = v[7:0];
    return s;
  endfunction

  assign w_a_in = '{'{io_sa.a_1_1, io_sa.a_1_2, io_sa.a_1_3, io_sa.a_1_4},
                    '{io_sa.a_2_1, io_sa.a_2_2, io_sa.a_2_3, io_sa.a_2_4},
                    '{io_sa.a_3_1, io_sa.a_3_2, io_sa.a_3_3, io_sa.a_3_4},
                    '{io_sa.a_4_1, io_sa.a_4_2, io_sa.a_4_3, io_sa.a_4_4}};
  assign w_b_in = '{'{io_sa.b_1_1, io_sa.b_1_2, io_sa.b_1_3},
                    '{io_sa.b_2_1, io_sa.b_2_2, io_sa.b_2_3},
                    '{io_sa.b_3_1, io_sa.b_3_2, io_sa.b_3_3}};

  // Skewed diagonal feed: PE row m works on output element (r_cnt - m), one step behind the row above
  always_comb begin
    for (int m = 0; m < 3; m++) begin
      w_k[m]       = r_cnt - 4'(m);
      w_row_vld[m] = ((r_state == LOAD) || (r_state == COMPUTE)) &&
                     (r_cnt >= 4'(m)) && (w_k[m] < 4'd4);
      for (int n = 0; n < 3; n++) begin
        if (w_row_vld[m]) begin
          w_feed[m][n] = r_a[2'(w_k[m][1]) + 2'(m)][2'(w_k[m][0]) + 2'(n)];
        end else begin
          w_feed[m][n] = 8'd0;
        end
        w_prod[m][n] = {8'd0, w_feed[m][n]} * {8'd0, r_b[m][n]};
      end
    end
    for (int n = 0; n < 3; n++) begin
      w_ps_in[0][n] = 20'd0;
      w_ps_in[1][n] = r_ps[0][n];
      w_ps_in[2][n] = r_ps[1][n];
    end
  end

  assign w_sum     = r_ps[2][0] + r_ps[2][1] + r_ps[2][2];
  assign w_cap     = (r_state != IDLE) && (r_cnt >= 4'd3) && (r_cnt <= 4'd6);
  assign w_cap_idx = 2'(r_cnt - 4'd3);
  assign w_out_idx = 2'(r_cnt - 4'd5);

  // Next-state and output-strobe decode
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_out_vld = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_sa.en_sa) begin
          w_start = 1'b1;
          w_next  = LOAD;
        end else begin
          w_next  = IDLE;
        end
      end
      LOAD:    w_next = COMPUTE;
      COMPUTE: begin
        if (r_cnt == 4'd5) begin
          w_next    = OUTPUT;
          w_out_vld = 1'b1;
        end else begin
          w_next    = COMPUTE;
        end
      end
      OUTPUT: begin
        w_out_vld = 1'b1;
        if (r_state == OUTPUT && r_cnt == 4'd8) w_next = IDLE;
        else                                    w_next = OUTPUT;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, step counter and operand latch; operands change only on an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) r_a[r][c] <= 8'd0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) r_b[r][c] <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt <= 4'd0;
        r_a   <= w_a_in;
        r_b   <= w_b_in;
      end else if (r_state != IDLE) begin
        r_cnt <= r_cnt + 4'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // PE array: each weight stays put while partial sums move down its column one register per step
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int m = 0; m < 3; m++)
        for (int n = 0; n < 3; n++) r_ps[m][n] <= 20'd0;
    end else begin
      for (int m = 0; m < 3; m++)
        for (int n = 0; n < 3; n++)
          if (w_row_vld[m]) r_ps[m][n] <= w_ps_in[m][n] + {4'd0, w_prod[m][n]};
          else              r_ps[m][n] <= 20'd0;
    end
  end

  // Result buffer and registered serial output
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r_res[k] <= 8'd0;
      r_vld <= 1'b0;
      r_out <= 8'd0;
    end else begin
      if (w_cap) r_res[w_cap_idx] <= sat8(w_sum);
      r_vld <= w_out_vld;
      r_out <= w_out_vld ? r_res[w_out_idx] : 8'd0;
    end
  end

  assign io_sa.sa_en_result = r_vld;
  assign io_sa.sa_result    = r_out;
endmodule

// File: tb/tb_sa_module_core.sv
// Bench for sa_module_core: fixed vectors from a table, hand-built reset/restart sequences,
// and back-to-back random operations scored against a plain-arithmetic correlation model.
module tb_sa_module_core;
  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  sa_module_core_if u_if();
  sa_module_core u_dut (.clk(clk), .reset(reset), .io_sa(u_if.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] a;    // byte (r*4+c) holds a_(r+1)_(c+1)
    logic [71:0]  b;    // byte (m*3+n) holds b_(m+1)_(n+1)
    logic [31:0]  exp;  // byte k holds the k-th result: C11, C12, C21, C22
    string        name;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic drive_ab(input logic [127:0] a, input logic [71:0] b);
    u_if.a_1_1 = a[7:0];     u_if.a_1_2 = a[15:8];    u_if.a_1_3 = a[23:16];   u_if.a_1_4 = a[31:24];
    u_if.a_2_1 = a[39:32];   u_if.a_2_2 = a[47:40];   u_if.a_2_3 = a[55:48];   u_if.a_2_4 = a[63:56];
    u_if.a_3_1 = a[71:64];   u_if.a_3_2 = a[79:72];   u_if.a_3_3 = a[87:80];   u_if.a_3_4 = a[95:88];
    u_if.a_4_1 = a[103:96];  u_if.a_4_2 = a[111:104]; u_if.a_4_3 = a[119:112]; u_if.a_4_4 = a[127:120];
    u_if.b_1_1 = b[7:0];     u_if.b_1_2 = b[15:8];    u_if.b_1_3 = b[23:16];
    u_if.b_2_1 = b[31:24];   u_if.b_2_2 = b[39:32];   u_if.b_2_3 = b[47:40];
    u_if.b_3_1 = b[55:48];   u_if.b_3_2 = b[63:56];   u_if.b_3_3 = b[71:64];
  endtask

  function automatic logic [127:0] rand_a(input int maxv);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'($urandom_range(0, maxv));
    return v;
  endfunction

  function automatic logic [71:0] rand_b(input int maxv);
    logic [71:0] v;
    for (int i = 0; i < 9; i++) v[8*i +: 8] = 8'($urandom_range(0, maxv));
    return v;
  endfunction

  // Reference: direct sum over the 3x3 window, then clamp to 255
  function automatic logic [31:0] ref_model(input logic [127:0] a, input logic [71:0] b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      int i = k / 2;
      int j = k % 2;
      int s = 0;
      for (int m = 0; m < 3; m++)
        for (int n = 0; n < 3; n++)
          s = s + int'(a[8*((i+m)*4 + j+n) +: 8]) * int'(b[8*(m*3+n) +: 8]);
      r[8*k +: 8] = (s > 255) ? 8'd255 : 8'(s);
    end
    return r;
  endfunction

  // Start at edge E0, then check edges E0+1..E0+9; inputs are scrambled after E0.
  // hold: cycles en_sa stays high from E0; extra: a second pulse sampled at E0+3.
  task automatic run_op(input logic [127:0] a, input logic [71:0] b, input logic [31:0] exp,
                        input int hold, input bit extra, input string tag);
    drive_ab(a, b);
    u_if.en_sa = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 9; c++) begin
      if (c == 1) drive_ab(rand_a(255), rand_b(255));
      u_if.en_sa = (c < hold) || (extra && c == 3);
      @(posedge clk);
      #1;
      chk($sformatf("%s_e%0d_vld", tag, c), 8'(u_if.sa_en_result), (c >= 6) ? 8'd1 : 8'd0);
      chk($sformatf("%s_e%0d_res", tag, c), u_if.sa_result, (c >= 6) ? exp[8*(c-6) +: 8] : 8'd0);
    end
    u_if.en_sa = 1'b0;
  endtask

  task automatic idle_check(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_%0d_vld", tag, c), 8'(u_if.sa_en_result), 8'd0);
      chk($sformatf("%s_%0d_res", tag, c), u_if.sa_result, 8'd0);
    end
  endtask

  initial begin
    logic [127:0] ra;
    logic [71:0]  rb;

    tbl[0] = '{a: {16{8'd1}}, b: {9{8'd1}}, exp: {8'd9, 8'd9, 8'd9, 8'd9}, name: "ones"};
    tbl[1] = '{a: {8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9,
                   8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               b: {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
               exp: {8'd11, 8'd10, 8'd7, 8'd6}, name: "center"};
    tbl[2] = '{a: tbl[1].a, b: {9{8'd1}}, exp: {8'd99, 8'd90, 8'd63, 8'd54}, name: "seq_ones"};
    tbl[3] = '{a: {8'd27, 8'd55, 8'd64, 8'd13, 8'd12, 8'd1, 8'd255, 8'd9,
                   8'd3, 8'd3, 8'd2, 8'd5, 8'd3, 8'd12, 8'd123, 8'd233},
               b: {8'd1, 8'd52, 8'd51, 8'd50, 8'd1, 8'd2, 8'd3, 8'd2, 8'd13},
               exp: {8'd255, 8'd255, 8'd255, 8'd255}, name: "saturate"};

    reset      = 1'b1;
    u_if.en_sa = 1'b0;
    drive_ab('0, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_vld", 8'(u_if.sa_en_result), 8'd0);
    chk("reset_res", u_if.sa_result, 8'd0);
    idle_check(3, "idle_after_reset");

    for (int t = 0; t < 4; t++) run_op(tbl[t].a, tbl[t].b, tbl[t].exp, 1, 1'b0, tbl[t].name);
    idle_check(1, "after_table");

    // Ignored second pulse at E0+3, and a start strobe held for four cycles
    run_op(tbl[2].a, tbl[2].b, tbl[2].exp, 1, 1'b1, "extra_pulse");
    run_op(tbl[1].a, tbl[1].b, tbl[1].exp, 4, 1'b0, "held_start");
    idle_check(2, "after_held");

    // Reset at E0+4 aborts the operation without any output pulse
    drive_ab(tbl[0].a, tbl[0].b);
    u_if.en_sa = 1'b1;
    @(posedge clk);
    #1;
    u_if.en_sa = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_reset_vld", 8'(u_if.sa_en_result), 8'd0);
    idle_check(8, "abort");
    run_op(tbl[2].a, tbl[2].b, tbl[2].exp, 1, 1'b0, "restart");

    // Reset wins over a simultaneous start
    reset      = 1'b1;
    u_if.en_sa = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    u_if.en_sa = 1'b0;
    idle_check(10, "reset_vs_start");

    // Back-to-back random operations, mixing small and full-range operands
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        ra = rand_a(7);
        rb = rand_b(7);
      end else begin
        ra = rand_a(255);
        rb = rand_b(255);
      end
      run_op(ra, rb, ref_model(ra, rb), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
             $sformatf("rand%0d", t));
    end
    idle_check(3, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
